// File: rtl/uart_rx_sampler_mv_if.sv
// Bus between the RX FSM side and the oversampling bit sampler.
// The FSM (master) drives the line, the bit-timing inputs and the enables.
// The sampler (slave) returns the synchronised line and the voted bit.
interface uart_rx_sampler_mv_if #(
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] prescale;
  logic                  dat_samp_en;
  logic                  vote_en;
  logic [PRESCALE_W-1:0] edge_count;
  logic                  rx_sync;
  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  noise_err;
  logic                  cfg_err;

  modport master (
    output RX_IN, prescale, dat_samp_en, vote_en, edge_count,
    input  rx_sync, sampled_bit, sample_valid, noise_err, cfg_err
  );

  modport slave (
    input  RX_IN, prescale, dat_samp_en, vote_en, edge_count,
    output rx_sync, sampled_bit, sample_valid, noise_err, cfg_err
  );
endinterface

// File: rtl/uart_rx_sampler_mv.sv
// UART RX oversampling bit sampler.
// Synchronises the RX line, captures NUM_SAMPLES oversamples centred on the
// bit midpoint (as indexed by the FSM's edge_count) and issues a
// majority-voted bit with a one-cycle valid strobe, a noise flag and a
// configuration-error flag.
module uart_rx_sampler_mv #(
  parameter int NUM_SAMPLES = 3,
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_rx_sampler_mv_if.slave  bus
);

  // All bit-timing arithmetic is done one bit wider than prescale so that
  // C+H+1 cannot wrap for large prescale values.
  localparam int                  W1   = PRESCALE_W + 1;
  localparam int                  HI   = (NUM_SAMPLES - 1) / 2;
  localparam logic [W1-1:0]       H    = W1'(HI);
  localparam logic [3:0]          H4   = 4'(HI);

  logic [W1-1:0]          w_ps_ext;
  logic [W1-1:0]          w_ec_ext;
  logic [W1-1:0]          w_c;
  logic [W1-1:0]          w_v;
  logic [W1-1:0]          w_base;
  logic                   w_legal;
  logic                   w_go;
  logic                   w_vote_hit;
  logic [NUM_SAMPLES-1:0] w_cap_hit;
  logic [3:0]             w_ones;
  logic                   w_maj;
  logic                   w_all_eq;
  logic                   w_rx_sync;

  logic [NUM_SAMPLES-1:0] r_cap;
  logic                   r_bit;
  logic                   r_valid;
  logic                   r_noise;
  logic                   r_cfg;

  // Line synchroniser; resets to the idle (mark) level.
  generate
    if (SYNC_STAGES == 0) begin : g_sync_bypass
      assign w_rx_sync = bus.RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Shift RX_IN through SYNC_STAGES flops.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_sync <= '1;
        end else begin
          r_sync[0] <= bus.RX_IN;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_rx_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_ps_ext = {1'b0, bus.prescale};
  assign w_ec_ext = {1'b0, bus.edge_count};
  assign w_c      = w_ps_ext >> 1;
  assign w_v      = w_c + H + W1'(1);
  assign w_base   = w_c - H;

  // The vote point must fall inside the bit (V <= prescale-1) and the first
  // capture must not precede edge 0.
  assign w_legal    = (w_c >= H) && (w_v < w_ps_ext);
  assign w_go       = bus.dat_samp_en && w_legal;
  assign w_vote_hit = (w_ec_ext == w_v);

  // Decode which capture slot (if any) the current edge_count selects.
  always_comb begin
    w_cap_hit = '0;
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      w_cap_hit[k] = (w_ec_ext == (w_base + W1'(k)));
    end
  end

  // Majority and agreement over the captured samples.
  always_comb begin
    w_ones = '0;
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      w_ones = w_ones + 4'(r_cap[k]);
    end
    w_maj    = (w_ones > H4);
    w_all_eq = (r_cap == '0) || (r_cap == '1);
  end

  // Capture register: loaded by index match, cleared whenever sampling is off.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cap <= '0;
    end else if (!bus.dat_samp_en) begin
      r_cap <= '0;
    end else if (w_legal) begin
      for (int k = 0; k < NUM_SAMPLES; k++) begin
        if (w_cap_hit[k]) begin
          r_cap[k] <= w_rx_sync;
        end
      end
    end
  end

  // Output registers: vote at V, one-cycle valid, noise and config flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
      r_noise <= 1'b0;
      r_cfg   <= 1'b0;
    end else begin
      r_cfg   <= !w_legal;
      r_valid <= w_go && w_vote_hit;
      if (!bus.dat_samp_en) begin
        r_noise <= 1'b0;
      end else if (w_go && w_vote_hit) begin
        r_bit   <= bus.vote_en ? w_maj : r_cap[HI];
        r_noise <= bus.vote_en && !w_all_eq;
      end
    end
  end

  assign bus.rx_sync      = w_rx_sync;
  assign bus.sampled_bit  = r_bit;
  assign bus.sample_valid = r_valid;
  assign bus.noise_err    = r_noise;
  assign bus.cfg_err      = r_cfg;

endmodule
